gf2m_poly_reducer: RTL and testbench
====================================

// Module: gf2m_poly_reducer
// PURPOSE
//   Sequential GF(2^M) modular reduction stage that consumes the 2M-bit carry-less
//   (XOR) product from the two-way Karatsuba multiplier. Reduces it modulo the
//   irreducible polynomial POLY and returns an M-bit field element.
//   Processes D bits per cycle, from MSB down, under a valid/ready handshake on both sides.
// PARAMETERS
//   M     256                      field degree; output width; input width is 2M
//   D     8                        bits reduced per cycle; 1 <= D <= M
//   POLY  x^256+x^10+x^5+x^2+1     reduction polynomial, M+1 bits, bit M must be 1
//                                  (default 257'h1_..._0425)
// PORTS
//   clk        in   1    clock, rising edge
//   rst        in   1    reset, synchronous, active-high
//   in_valid   in   1    product on a is valid
//   in_ready   out  1    block can accept a product
//   a          in   2M   carry-less product, bit i = coefficient of x^i
//   out_valid  out  1    c holds the reduced result
//   out_ready  in   1    consumer accepts c
//   c          out  M    a mod POLY over GF(2)
//   busy       out  1    1 while in state REDUCE
// BEHAVIOUR
//   - Reset: state=IDLE, working reg r=0, idx=2M-1, c=0, out_valid=0, busy=0.
//     in_ready=1 from the first cycle after reset.
//   - rst has priority over everything. Mid-REDUCE or mid-DONE it aborts the operation;
//     the partial result is discarded and never presented.
//   - FSM IDLE -> REDUCE -> DONE -> IDLE:
//     IDLE: in_ready=1. On in_valid&&in_ready: r<=a, idx<=2M-1, state<=REDUCE.
//     REDUCE: in_ready=0, busy=1. Each edge runs D sequential steps for j=idx..idx-D+1:
//       if j>=M and r[j]==1 then r ^= POLY<<(j-M). Steps with j<M are no-ops.
//       Then idx<=idx-D. When the new idx < M: state<=DONE, c<=r[M-1:0], out_valid<=1.
//     DONE: out_valid=1, c held stable. On out_ready: out_valid<=0, state<=IDLE.
//       The input is not accepted in the same cycle.
//   - Latency: N = ceil(M/D) REDUCE edges. For M=256, D=8, N=32.
//     out_valid rises after edge T+N, where T is the accepting edge.
//     Minimum initiation interval is N+2 cycles.
//   - Arithmetic is pure XOR with no carries; r is 2M bits wide.
//     Bit 2M-1 of a is reduced like any other bit, although a Karatsuba product never sets it.
//   - a is sampled only on the accepting edge. Later changes on a have no effect.
//   - in_valid while busy is ignored (held off by in_ready=0); the source must hold it.
//   - out_valid never drops without out_ready. Once asserted, c is stable until the handshake.
//   - Input already < x^M passes through unchanged after the same N-cycle latency.
//     The latency is data-independent, with no early exit.
// TESTING
//   1 a=x^256 (bit 256 only) -> c=256'h425 after exactly 32 edges; busy high for 32 cycles.
//   2 a=x^511 -> c = x^255+x^19+x^4+x^3+x
//     = 256'h8000...0008_001A (bit255|0x8001A).
//   3 a=0, then a=256'h1234 (<x^M) -> c=0 and c=256'h1234 respectively; latency 32 each.
//   4 Backpressure: hold out_ready=0 for 10 cycles after out_valid.
//     -> out_valid and c stay stable, in_ready=0. Release -> IDLE, in_ready=1 next cycle.
//   5 Reset mid-op: accept a=x^511, assert rst at edge T+5
//     -> next cycle: state IDLE, out_valid=0, c=0, in_ready=1.
//     A fresh a=x^256 then yields 256'h425.
//   6 Random: 1000 products of random 256-bit a,b from the Karatsuba multiplier
//     -> c matches golden-model clmul(a,b) mod POLY. Also run D=1 and D=256 (N=256, N=1).

Source files
------------

// File: rtl/gf2m_poly_reducer.sv
// Sequential GF(2^M) reducer: folds a 2M-bit carry-less product modulo POLY,
// retiring D coefficients per clock from the MSB down, with valid/ready on both sides.
module gf2m_poly_reducer #(
    parameter int         M    = 256,
    parameter int         D    = 8,
    parameter logic [M:0] POLY = {1'b1, {(M-11){1'b0}}, 11'h425}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*M-1:0] a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   c,
    output logic           busy
);

    localparam int              IW      = $clog2(2*M);
    localparam logic [IW-1:0]   IDX_TOP = IW'(2*M-1);
    localparam logic [IW-1:0]   IDX_M   = IW'(M);
    localparam logic [IW-1:0]   IDX_D   = IW'(D);
    localparam logic [2*M-1:0]  POLY_EXT = {{(M-1){1'b0}}, POLY};

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t          state_q;
    logic [2*M-1:0]  r_q, r_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [M-1:0]    c_q;
    logic            out_valid_q, in_ready_q, busy_q;

    // D chained reduction steps for coefficients idx..idx-D+1; positions below M are left alone.
    always_comb begin
        logic [IW-1:0] j;
        j   = '0;
        r_d = r_q;
        for (int k = 0; k < D; k++) begin
            j = idx_q - IW'(k);
            if (j >= IDX_M && r_d[j]) begin
                r_d = r_d ^ (POLY_EXT << (j - IDX_M));
            end
        end
    end

    assign idx_d = idx_q - IDX_D;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            idx_q       <= IDX_TOP;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        r_q        <= a;
                        idx_q      <= IDX_TOP;
                        state_q    <= REDUCE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                REDUCE: begin
                    r_q   <= r_d;
                    idx_q <= idx_d;
                    if (idx_d < IDX_M) begin
                        state_q     <= DONE;
                        c_q         <= r_d[M-1:0];
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                DONE: begin
                    // New input is only taken once back in IDLE, never on the handshake edge.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gf2m_poly_reducer.sv
// Bench for gf2m_poly_reducer: three instances (D=8, D=1, D=256) run side by side
// against a fold-based reference (x^256 == x^10+x^5+x^2+1) and fixed vectors.
module tb_gf2m_poly_reducer;

    localparam int M = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] a;
    logic         out_ready;
    logic         iv [3];
    logic         ir [3];
    logic         ov [3];
    logic         bz [3];
    logic [255:0] cc [3];

    int tests = 0;
    int fails = 0;
    int nlat [3] = '{32, 256, 1};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int DD = (gi == 0) ? 8 : (gi == 1) ? 1 : 256;
        gf2m_poly_reducer #(.M(M), .D(DD)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[gi]),
            .in_ready  (ir[gi]),
            .a         (a),
            .out_valid (ov[gi]),
            .out_ready (out_ready),
            .c         (cc[gi]),
            .busy      (bz[gi])
        );
    end

    typedef struct {
        logic [511:0] a;
        logic [255:0] c;
    } vec_t;

    vec_t vt [7];

    function automatic logic [511:0] one_hot(input int n);
        logic [511:0] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] clmul(input logic [511:0] x, input logic [255:0] y);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) if (y[i]) r = r ^ (x << i);
        return r;
    endfunction

    // Fold the high half back down with x^256 = tail until nothing remains above x^255.
    function automatic logic [255:0] ref_mod(input logic [511:0] v_in);
        logic [511:0] v, h;
        logic [255:0] tail;
        tail = 256'h425;
        v    = v_in;
        for (int g = 0; g < 8; g++) begin
            h = v >> 256;
            if (h != '0) v = {256'b0, v[255:0]} ^ clmul(h, tail);
        end
        return v[255:0];
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input logic [511:0] av, input logic [255:0] exp, input bit en1, input string nm);
        bit           en [3];
        bit           done [3];
        int           lat [3];
        int           bcnt [3];
        logic [255:0] got [3];
        bit           all_done;
        int           cyc;
        en = '{1'b1, en1, 1'b1};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (en[i]) chk($sformatf("%s ready%0d", nm, i), ir[i], 1'b1);
            iv[i]   = en[i];
            done[i] = 1'b0;
            lat[i]  = -1;
            bcnt[i] = 0;
            got[i]  = '0;
        end
        a         = av;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
        a = {rand256(), rand256()};
        cyc      = 0;
        all_done = 1'b0;
        while (!all_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            all_done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (en[i] && !done[i]) begin
                    if (bz[i]) bcnt[i]++;
                    if (ov[i]) begin
                        done[i] = 1'b1;
                        lat[i]  = cyc - 1;
                        got[i]  = cc[i];
                    end
                end
                if (en[i] && !done[i]) all_done = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                chk($sformatf("%s c%0d", nm, i), got[i], exp);
                chk($sformatf("%s latency%0d", nm, i), 256'(lat[i]), 256'(nlat[i]));
                chk($sformatf("%s busy_cycles%0d", nm, i), 256'(bcnt[i]), 256'(nlat[i]));
                $display("[TB] %s inst%0d c=%h lat=%0d", nm, i, got[i], lat[i]);
            end
        end
    endtask

    initial begin
        logic [511:0] p;
        logic [255:0] held;
        int           cyc;
        int           bad;

        vt[0] = '{one_hot(256), 256'h425};
        vt[1] = '{one_hot(511), (256'b1 << 255) | 256'h8001A};
        vt[2] = '{512'h0, 256'h0};
        vt[3] = '{512'h1234, 256'h1234};
        vt[4] = '{one_hot(266), 256'h109400};
        vt[5] = '{one_hot(256) | 512'h1, 256'h424};
        vt[6] = '{one_hot(255), 256'b1 << 255};

        rst       = 1'b1;
        a         = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset in_ready", ir[0], 1'b1);
        chk("reset out_valid", ov[0], 1'b0);
        chk("reset busy", bz[0], 1'b0);
        chk("reset c", cc[0], 256'h0);

        for (int v = 0; v < 7; v++) run_txn(vt[v].a, vt[v].c, 1'b1, $sformatf("vec%0d", v));

        // Backpressure: result must hold while out_ready stays low.
        @(negedge clk);
        a         = one_hot(256);
        iv[0]     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        cyc = 0;
        while (!ov[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp out_valid", ov[0], 1'b1);
        held = cc[0];
        chk("bp c", held, 256'h425);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov[0] !== 1'b1 || cc[0] !== held || ir[0] !== 1'b0) bad++;
        end
        chk("bp stable", 256'(bad), 256'h0);
        a         = 512'h1234;
        iv[0]     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release out_valid", ov[0], 1'b0);
        chk("bp release in_ready", ir[0], 1'b1);
        chk("bp no accept on handshake", bz[0], 1'b0);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        chk("bp accept next", bz[0], 1'b1);
        cyc = 0;
        while (!ov[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp second c", cc[0], 256'h1234);
        $display("[TB] backpressure sequence done");

        // Reset in the middle of a reduction.
        @(negedge clk);
        a     = one_hot(511);
        iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst out_valid", ov[0], 1'b0);
        chk("midrst c", cc[0], 256'h0);
        chk("midrst in_ready", ir[0], 1'b1);
        chk("midrst busy", bz[0], 1'b0);
        $display("[TB] mid-operation reset done");
        run_txn(one_hot(256), 256'h425, 1'b1, "post_rst");

        // Random Karatsuba-style products.
        for (int k = 0; k < 1000; k++) begin
            p = clmul({256'b0, rand256()}, rand256());
            run_txn(p, ref_mod(p), (k < 60), $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
